nco_sweep_ctrl: RTL

Frequency-sweep sequencer for the acquisition NCO. It drives the NCO's 32-bit phase increment, clock enable and reset, and steps the increment through a programmed list of frequencies. At each frequency it discards a settling window and then flags a fixed number of valid samples for downstream capture. It sits between the acquisition control registers and the NCO instance in the OCT acquisition path.

---
 rtl/nco_sweep_ctrl_if.sv | 38 +++
 rtl/nco_sweep_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl_if.sv
// Bundle of control, configuration, status and NCO-side signals of the
// frequency-sweep sequencer. The master side is the acquisition control
// logic that requests sweeps and returns NCO out_valid; the slave side is
// the sequencer itself.
interface nco_sweep_ctrl_if #(
    parameter int unsigned PHI_W = 32,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [PHI_W-1:0] phi_start_i;
    logic [PHI_W-1:0] phi_step_i;
    logic [CNT_W-1:0] num_steps_i;
    logic [CNT_W-1:0] dwell_i;
    logic             nco_valid_i;
    logic [PHI_W-1:0] phi_inc_o;
    logic             nco_clken_o;
    logic             nco_reset_n_o;
    logic             sample_en_o;
    logic [CNT_W-1:0] step_idx_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    modport master (
        output start, abort, phi_start_i, phi_step_i, num_steps_i, dwell_i,
               nco_valid_i,
        input  phi_inc_o, nco_clken_o, nco_reset_n_o, sample_en_o,
               step_idx_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start, abort, phi_start_i, phi_step_i, num_steps_i, dwell_i,
               nco_valid_i,
        output phi_inc_o, nco_clken_o, nco_reset_n_o, sample_en_o,
               step_idx_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for the acquisition NCO. Steps the NCO phase
// increment through a programmed list, discards a settling window of valid
// samples after each change and then flags a fixed number of samples for
// capture. All outputs are registered.
module nco_sweep_ctrl #(
    parameter int unsigned PHI_W    = 32,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned SETTLE   = 8,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    nco_sweep_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_NCO_RST    = 3'd1;
    localparam logic [2:0] S_WAIT_VALID = 3'd2;
    localparam logic [2:0] S_SETTLE     = 3'd3;
    localparam logic [2:0] S_DWELL      = 3'd4;
    localparam logic [2:0] S_STEP       = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    // With no settling window an increment change leads straight to capture.
    localparam logic [2:0] S_AFTER_CHANGE = (SETTLE == 0) ? S_DWELL : S_SETTLE;

    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int unsigned SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'((SETTLE == 0) ? 0 : SETTLE - 1);

    logic [2:0]        r_state;
    logic              r_rst_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [SET_W-1:0]  r_settle_cnt;
    logic [CNT_W-1:0]  r_dwell_cnt;
    logic [PHI_W-1:0]  r_phi;
    logic [PHI_W-1:0]  r_phi_step;
    logic [CNT_W-1:0]  r_num_steps;
    logic [CNT_W-1:0]  r_dwell;
    logic [CNT_W-1:0]  r_step_idx;
    logic              r_clken;
    logic              r_nco_rst_n;
    logic              r_sample_en;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [CNT_W-1:0]  w_num_eff;
    logic [CNT_W-1:0]  w_dwell_eff;
    logic              w_last_step;
    logic              w_dwell_last;

    // Zero-to-one substitution of the request and end-of-window detection.
    always_comb begin
        w_num_eff    = (bus.num_steps_i == '0) ? CNT_W'(1) : bus.num_steps_i;
        w_dwell_eff  = (bus.dwell_i == '0) ? CNT_W'(1) : bus.dwell_i;
        w_last_step  = (r_step_idx == (r_num_steps - CNT_W'(1)));
        w_dwell_last = (r_dwell_cnt == (r_dwell - CNT_W'(1)));
    end

    // Sweep sequencer: state, counters and every registered output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_rst_cnt    <= 1'b0;
            r_wait_cnt   <= '0;
            r_settle_cnt <= '0;
            r_dwell_cnt  <= '0;
            r_phi        <= '0;
            r_phi_step   <= '0;
            r_num_steps  <= '0;
            r_dwell      <= '0;
            r_step_idx   <= '0;
            r_clken      <= 1'b0;
            r_nco_rst_n  <= 1'b0;
            r_sample_en  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_state != S_DONE) begin
                r_done <= 1'b0;
            end
            if (bus.abort) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_clken     <= 1'b0;
                r_nco_rst_n <= 1'b0;
                r_sample_en <= 1'b0;
                r_done      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_phi       <= bus.phi_start_i;
                            r_phi_step  <= bus.phi_step_i;
                            r_num_steps <= w_num_eff;
                            r_dwell     <= w_dwell_eff;
                            r_step_idx  <= '0;
                            r_rst_cnt   <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_NCO_RST;
                        end
                    end
                    S_NCO_RST: begin
                        if (r_rst_cnt) begin
                            r_nco_rst_n <= 1'b1;
                            r_clken     <= 1'b1;
                            r_wait_cnt  <= '0;
                            r_state     <= S_WAIT_VALID;
                        end else begin
                            r_rst_cnt <= 1'b1;
                        end
                    end
                    S_WAIT_VALID: begin
                        if (bus.nco_valid_i) begin
                            r_settle_cnt <= '0;
                            r_dwell_cnt  <= '0;
                            r_state      <= S_AFTER_CHANGE;
                        end else if (r_wait_cnt == WAIT_LAST) begin
                            r_err       <= 1'b1;
                            r_busy      <= 1'b0;
                            r_clken     <= 1'b0;
                            r_nco_rst_n <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (bus.nco_valid_i) begin
                            if (r_settle_cnt == SETTLE_LAST) begin
                                r_dwell_cnt <= '0;
                                r_state     <= S_DWELL;
                            end else begin
                                r_settle_cnt <= r_settle_cnt + SET_W'(1);
                            end
                        end
                    end
                    S_DWELL: begin
                        r_sample_en <= bus.nco_valid_i;
                        if (bus.nco_valid_i) begin
                            if (w_dwell_last) begin
                                if (w_last_step) begin
                                    r_clken     <= 1'b0;
                                    r_nco_rst_n <= 1'b0;
                                    r_state     <= S_DONE;
                                end else begin
                                    r_state <= S_STEP;
                                end
                            end else begin
                                r_dwell_cnt <= r_dwell_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_STEP: begin
                        r_sample_en  <= 1'b0;
                        r_phi        <= r_phi + r_phi_step;
                        r_step_idx   <= r_step_idx + CNT_W'(1);
                        r_settle_cnt <= '0;
                        r_dwell_cnt  <= '0;
                        r_state      <= S_AFTER_CHANGE;
                    end
                    S_DONE: begin
                        // DONE spans two cycles: the first lets the last
                        // sample_en drain, the second carries the done pulse
                        // while busy is still high.
                        r_sample_en <= 1'b0;
                        if (!r_done) begin
                            r_done <= 1'b1;
                        end else begin
                            r_done  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_busy      <= 1'b0;
                        r_clken     <= 1'b0;
                        r_nco_rst_n <= 1'b0;
                        r_sample_en <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.phi_inc_o     = r_phi;
    assign bus.nco_clken_o   = r_clken;
    assign bus.nco_reset_n_o = r_nco_rst_n;
    assign bus.sample_en_o   = r_sample_en;
    assign bus.step_idx_o    = r_step_idx;
    assign bus.busy_o        = r_busy;
    assign bus.done_o        = r_done;
    assign bus.err_o         = r_err;
endmodule
